// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (16x oversampling) feeding a
// first-word-fall-through byte FIFO drained by a read strobe.
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   rx_serial           - asynchronous serial line, idle high
//   rd_en               - pop FIFO head (ignored when empty)
//   rd_data, rd_valid   - FIFO head byte and not-empty flag
//   fifo_full           - FIFO holds FIFO_DEPTH entries
//   busy                - frame reception in progress
//   frame_error         - one-cycle pulse, stop bit sampled low
//   overrun             - sticky, byte dropped on full FIFO
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_serial,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       fifo_full,
    output logic       busy,
    output logic       frame_error,
    output logic       overrun
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, rx_s_q;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [3:0]      tick_cnt_q, tick_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            frame_error_q, frame_error_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic tick;
    logic push;
    logic pop;
    logic full;

    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign rd_valid    = (count_q != '0);
    assign fifo_full   = full;
    assign rd_data     = mem_q[rd_ptr_q];
    assign busy        = (state_q != S_IDLE);
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

    always_comb begin
        tick          = (div_cnt_q == DW'(DIV - 1));
        pop           = rd_en && rd_valid;
        push          = 1'b0;
        state_d       = state_q;
        div_cnt_d     = tick ? '0 : div_cnt_q + DW'(1);
        tick_cnt_d    = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        frame_error_d = 1'b0;
        overrun_d     = overrun_q;

        unique case (state_q)
            S_IDLE: begin
                // Realign the oversampling grid to the start edge.
                if (!rx_s_q) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    div_cnt_d  = '0;
                end
            end
            S_START: begin
                if (tick && tick_cnt_q == 4'd7) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_DATA;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
            end
            S_DATA: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                        // A same-cycle pop frees a slot for this byte.
                        if (!full || pop) begin
                            push = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q       <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= S_IDLE;
            div_cnt_q     <= '0;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync1_q       <= rx_serial;
            rx_s_q        <= sync1_q;
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mem_q         <= mem_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames into uart_rx_fifo with a
// scoreboard of expected bytes checked by an independent pop monitor.
module tb_uart_rx_fifo;

    logic       clock;
    logic       reset;
    logic       rx_serial;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       fifo_full;
    logic       busy;
    logic       frame_error;
    logic       overrun;

    int tests;
    int fails;
    int fe_cnt;
    logic [7:0] exp_q [$];

    uart_rx_fifo #(
        .CLK_FREQ  (1600000),
        .BAUD      (100000),
        .FIFO_DEPTH(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_serial  (rx_serial),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_full  (fifo_full),
        .busy       (busy),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance n clock edges, then settle 1 time unit past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_data(input logic [7:0] b);
        rx_serial = 1'b0;
        cyc(16);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            cyc(16);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_data(b);
        rx_serial = 1'b1;
        cyc(16);
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic watch_valid(output int n);
        n = 0;
        while (!rd_valid && n < 300) begin
            cyc(1);
            n++;
        end
    endtask

    // Monitor: a pop is observed one half-cycle before the edge
    // that performs it; the head byte must match the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (frame_error) fe_cnt++;
            if (rd_valid && rd_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", {24'd0, rd_data}, 32'hFFFF);
                end else begin
                    check("pop_data", {24'd0, rd_data},
                          {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int n;
        tests     = 0;
        fails     = 0;
        fe_cnt    = 0;
        reset     = 1'b1;
        rx_serial = 1'b1;
        rd_en     = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(1);

        check("rst_rd_valid", rd_valid, 0);
        check("rst_fifo_full", fifo_full, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_data", rd_data, 8'h00);

        // Single byte with latency measured from the start edge.
        exp_q.push_back(8'hA5);
        fork
            send_byte(8'hA5);
            watch_valid(lat);
        join
        check("a5_latency", lat, 155);
        check("a5_busy", busy, 0);
        check("a5_fe", fe_cnt, 0);
        check("a5_valid", rd_valid, 1);
        pop1();
        check("a5_valid_drop", rd_valid, 0);

        // Glitch: 5 low clocks must not start a frame.
        rx_serial = 1'b0;
        cyc(5);
        rx_serial = 1'b1;
        n = 0;
        while (busy && n < 10) begin
            cyc(1);
            n++;
        end
        check("glitch_busy", busy, 0);
        cyc(20);
        check("glitch_valid", rd_valid, 0);
        check("glitch_fe", fe_cnt, 0);

        // Framing error: stop bit low for 3 bit times.
        send_data(8'h3C);
        rx_serial = 1'b0;
        cyc(48);
        check("fe_wait_high_busy", busy, 1);
        check("fe_count", fe_cnt, 1);
        rx_serial = 1'b1;
        cyc(4);
        check("fe_idle", busy, 0);
        check("fe_no_push", rd_valid, 0);
        exp_q.push_back(8'h11);
        send_byte(8'h11);
        check("fe_11_valid", rd_valid, 1);
        pop1();
        check("fe_count_final", fe_cnt, 1);

        // Fill and overrun.
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i));
        end
        check("fill_full", fifo_full, 1);
        check("fill_no_ovr", overrun, 0);
        send_byte(8'h05);
        check("ovr_set", overrun, 1);
        check("ovr_full", fifo_full, 1);
        for (int i = 0; i < 4; i++) pop1();
        check("drain_valid", rd_valid, 0);
        check("drain_queue", exp_q.size(), 0);

        // Simultaneous push and pop on a full FIFO.
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("reset_ovr_clr", overrun, 0);
        exp_q.push_back(8'h10);
        send_byte(8'h10);
        exp_q.push_back(8'h20);
        send_byte(8'h20);
        exp_q.push_back(8'h30);
        send_byte(8'h30);
        exp_q.push_back(8'h40);
        send_byte(8'h40);
        check("sim_full", fifo_full, 1);
        exp_q.push_back(8'h77);
        send_data(8'h77);
        rx_serial = 1'b1;
        cyc(10);
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        cyc(5);
        check("sim_no_ovr", overrun, 0);
        check("sim_still_full", fifo_full, 1);
        for (int i = 0; i < 4; i++) pop1();
        check("sim_drain_valid", rd_valid, 0);
        check("sim_queue", exp_q.size(), 0);

        // Reset mid-frame clears FIFO content and the partial byte.
        send_byte(8'h5A);
        check("pre_rst_valid", rd_valid, 1);
        check("pre_rst_data", rd_data, 8'h5A);
        rx_serial = 1'b0;
        cyc(16);
        for (int i = 0; i < 3; i++) begin
            rx_serial = 1'b1;
            cyc(16);
        end
        cyc(8);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("mrst_valid", rd_valid, 0);
        check("mrst_full", fifo_full, 0);
        check("mrst_busy", busy, 0);
        check("mrst_fe", frame_error, 0);
        check("mrst_ovr", overrun, 0);
        check("mrst_data", rd_data, 8'h00);
        cyc(100);
        check("mrst_no_push", rd_valid, 0);
        exp_q.push_back(8'h42);
        send_byte(8'h42);
        check("b42_valid", rd_valid, 1);
        pop1();
        check("b42_empty", rd_valid, 0);
        check("final_queue", exp_q.size(), 0);
        check("final_fe", fe_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
